// File: rtl/miriscv_dmem_pkg.sv
// Data-memory responder package: FSM state encoding and latency counter width.
package miriscv_dmem_pkg;

    localparam int DMEM_CNT_W = 4;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_WAIT = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/miriscv_lsu_pkg.sv
// LSU package: access-size codes shared between the load/store unit and its memories.
package miriscv_lsu_pkg;

    localparam int MEM_ACCESS_W = 3;

    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_WORD  = 3'd0;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_HALF  = 3'd1;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_BYTE  = 3'd2;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UHALF = 3'd3;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UBYTE = 3'd4;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_DWORD = 3'd5;
    localparam logic [MEM_ACCESS_W-1:0] MEM_ACCESS_UWORD = 3'd6;

endpackage

// File: rtl/miriscv_dmem_align.sv
// Combinational lane steering: byte enables, store shift, load extract/extend and
// size/alignment error for one LSU access.
module miriscv_dmem_align
    import miriscv_lsu_pkg::*;
(
    input  logic [MEM_ACCESS_W-1:0] size,
    input  logic [1:0]              offset,
    input  logic                    we,
    input  logic [31:0]             wdata,
    input  logic [31:0]             rword,
    output logic [3:0]              be,
    output logic [31:0]             wdata_sh,
    output logic [31:0]             rdata_ext,
    output logic                    err
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rword >> {offset, 3'b000};
        wdata_sh  = wdata << {offset, 3'b000};
        be        = 4'b0000;
        rdata_ext = shifted;
        err       = 1'b0;
        case (size)
            MEM_ACCESS_WORD: begin
                be  = 4'b1111;
                err = (offset != 2'b00);
            end
            MEM_ACCESS_HALF: begin
                be        = offset[1] ? 4'b1100 : 4'b0011;
                err       = offset[0];
                rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            end
            MEM_ACCESS_BYTE: begin
                be        = 4'b0001 << offset;
                rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            end
            // Unsigned codes only make sense for loads.
            MEM_ACCESS_UHALF: begin
                err       = offset[0] | we;
                rdata_ext = {16'h0000, shifted[15:0]};
            end
            MEM_ACCESS_UBYTE: begin
                err       = we;
                rdata_ext = {24'h000000, shifted[7:0]};
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/miriscv_dmem_responder.sv
// Word-addressed data memory answering one LSU request at a time after RESP_LATENCY cycles.
// Define MIRISCV_DMEM_ERR_EN to report access errors on data_err_o (otherwise tied to 0).
module miriscv_dmem_responder
    import miriscv_lsu_pkg::*;
    import miriscv_dmem_pkg::*;
#(
    parameter int MEM_DEPTH    = 1024,
    parameter int RESP_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [MEM_ACCESS_W-1:0] data_size_i,
    input  logic [31:0]             data_addr_i,
    input  logic [31:0]             data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [31:0]             data_rdata_o,
    output logic                    data_err_o,
    output dmem_state_e             dbg_state
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    dmem_state_e           state;
    logic [DMEM_CNT_W-1:0] cnt;
    logic [31:0]           mem [MEM_DEPTH];
    logic [IDX_W-1:0]      idx;
    logic [3:0]            be;
    logic [31:0]           wdata_sh;
    logic [31:0]           rdata_ext;
    logic                  align_err;
    logic                  range_err;
    logic                  bad;
    logic [31:0]           nxt_data;
    logic                  nxt_err;
    logic [31:0]           pend_data;
    logic                  pend_err;

    assign data_gnt_o = data_req_i && (state == DMEM_IDLE);
    assign dbg_state  = state;
    assign idx        = data_addr_i[IDX_W+1:2];
    assign range_err  = data_addr_i[31:2] >= 30'(MEM_DEPTH);
    assign bad        = align_err | range_err;
    assign nxt_data   = (data_we_i || bad) ? 32'h0 : rdata_ext;

`ifdef MIRISCV_DMEM_ERR_EN
    assign nxt_err = bad;
`else
    assign nxt_err = 1'b0;
`endif

    miriscv_dmem_align u_align (
        .size      (data_size_i),
        .offset    (data_addr_i[1:0]),
        .we        (data_we_i),
        .wdata     (data_wdata_i),
        .rword     (mem[idx]),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .err       (align_err)
    );

    // Stores commit at the grant edge, so a later load never needs a bypass.
    always_ff @(posedge clk_i) begin
        if (data_gnt_o && data_we_i && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= DMEM_IDLE;
            cnt           <= '0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= 32'h0;
            data_err_o    <= 1'b0;
            pend_data     <= 32'h0;
            pend_err      <= 1'b0;
        end else begin
            data_rvalid_o <= 1'b0;
            case (state)
                DMEM_IDLE: begin
                    if (data_gnt_o) begin
                        if (RESP_LATENCY == 1) begin
                            data_rvalid_o <= 1'b1;
                            data_rdata_o  <= nxt_data;
                            data_err_o    <= nxt_err;
                        end else begin
                            // Outputs keep their old values until the response pulse.
                            pend_data <= nxt_data;
                            pend_err  <= nxt_err;
                            cnt       <= DMEM_CNT_W'(RESP_LATENCY - 1);
                            state     <= DMEM_WAIT;
                        end
                    end
                end
                DMEM_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == DMEM_CNT_W'(1)) begin
                        data_rvalid_o <= 1'b1;
                        data_rdata_o  <= pend_data;
                        data_err_o    <= pend_err;
                        state         <= DMEM_IDLE;
                    end
                end
                default: state <= DMEM_IDLE;
            endcase
        end
    end

endmodule
